wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 8 x 16-bit register file. Shares its single write port between the ALU and memory-load result paths with valid/ready handshakes and round-robin arbitration, and drives `write_en`/`wreg`/`writedata` from registers. It also keeps a per-register pending-write scoreboard so the issue stage can stall reads and writes to registers with a result in flight.

---
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: round-robin share of the regfile write port plus pending-write scoreboard.
// Define WB_R0_ZERO_EN to make register 0 a hardwired zero (writes and marks to it are dropped).
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [2:0]  alu_wreg,
  input  logic [15:0] alu_data,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [2:0]  mem_wreg,
  input  logic [15:0] mem_data,
  input  logic        iss_valid,
  input  logic [2:0]  iss_reg,
  output logic        iss_ready,
  output logic [7:0]  busy,
  output logic        write_en,
  output logic [2:0]  wreg,
  output logic [15:0] writedata,
  output logic        err
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  grant_e      last_q, last_d;
  logic [7:0]  busy_q, busy_d;
  logic        we_q, we_d;
  logic [2:0]  wreg_q, wreg_d;
  logic [15:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        alu_pick;
  logic        mem_pick;
  logic        xfer;
  logic [2:0]  win_reg;
  logic [15:0] win_data;
  logic        keep_w;
  logic        iss_set;

  always_comb begin
    alu_pick  = alu_valid & (~mem_valid | (last_q == GNT_MEM));
    mem_pick  = mem_valid & ~alu_pick;
    alu_ready = ~rst & alu_pick;
    mem_ready = ~rst & mem_pick;
    iss_ready = ~rst & ~busy_q[iss_reg];
    xfer      = alu_ready | mem_ready;
    win_reg   = mem_pick ? mem_wreg : alu_wreg;
    win_data  = mem_pick ? mem_data : alu_data;
`ifdef WB_R0_ZERO_EN
    keep_w    = (win_reg != 3'd0);
    iss_set   = iss_valid & iss_ready & (iss_reg != 3'd0);
`else
    keep_w    = 1'b1;
    iss_set   = iss_valid & iss_ready;
`endif
  end

  always_comb begin
    last_d  = last_q;
    we_d    = xfer & keep_w;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    err_d   = err_q;
    if (xfer) begin
      last_d = mem_pick ? GNT_MEM : GNT_ALU;
    end
    if (we_d) begin
      wreg_d  = win_reg;
      wdata_d = win_data;
    end
    if (we_q) begin
      if (!busy_q[wreg_q]) begin
        err_d = 1'b1;
      end
      busy_d[wreg_q] = 1'b0;
    end
    // a fresh mark overrides the retiring write's clear
    if (iss_set) begin
      busy_d[iss_reg] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= GNT_ALU;
      busy_q  <= 8'h00;
      we_q    <= 1'b0;
      wreg_q  <= 3'd0;
      wdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      last_q  <= last_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wreg_q  <= wreg_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign busy      = busy_q;
  assign write_en  = we_q;
  assign wreg      = wreg_q;
  assign writedata = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vectors, literal checks and a per-cycle model compare.
// Builds with or without WB_R0_ZERO_EN.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [2:0]  alu_wreg = 3'd0;
  logic [15:0] alu_data = 16'h0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [2:0]  mem_wreg = 3'd0;
  logic [15:0] mem_data = 16'h0;
  logic        iss_valid = 1'b0;
  logic [2:0]  iss_reg = 3'd0;
  logic        iss_ready;
  logic [7:0]  busy;
  logic        write_en;
  logic [2:0]  wreg;
  logic [15:0] writedata;
  logic        err;

  int total = 0;
  int bad = 0;

  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .alu_wreg(alu_wreg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wreg(mem_wreg), .mem_data(mem_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .iss_ready(iss_ready), .busy(busy),
    .write_en(write_en), .wreg(wreg),
    .writedata(writedata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // model: who owns the port, which regs have a result in flight
  bit        m_init = 1'b0;
  bit        m_last = 1'b0;
  bit [7:0]  m_busy = 8'h00;
  bit        m_we = 1'b0;
  bit [2:0]  m_wreg = 3'd0;
  bit [15:0] m_wdata = 16'h0;
  bit        m_err = 1'b0;

  function automatic bit [1:0] pred_grant();
    if (rst) return 2'b00;
    if (alu_valid && mem_valid)
      return m_last ? 2'b01 : 2'b10;
    return {mem_valid, alu_valid};
  endfunction

  function automatic bit pred_iss();
    return !rst && !m_busy[iss_reg];
  endfunction

  always @(posedge clk) begin : model
    bit [1:0]  g;
    bit [7:0]  nb;
    bit [2:0]  dst;
    bit        drop;
    bit        issok;
    if (rst) begin
      m_init  <= 1'b1;
      m_last  <= 1'b0;
      m_busy  <= 8'h00;
      m_we    <= 1'b0;
      m_wreg  <= 3'd0;
      m_wdata <= 16'h0;
      m_err   <= 1'b0;
    end else begin
      g     = pred_grant();
      nb    = m_busy;
      dst   = g[1] ? mem_wreg : alu_wreg;
      drop  = 1'b0;
      issok = iss_valid && pred_iss();
`ifdef WB_R0_ZERO_EN
      drop  = (dst == 3'd0);
      issok = issok && (iss_reg != 3'd0);
`endif
      if (m_we) begin
        if (!m_busy[m_wreg]) m_err <= 1'b1;
        nb[m_wreg] = 1'b0;
      end
      if (issok) nb[iss_reg] = 1'b1;
      m_busy <= nb;
      if (g != 2'b00) m_last <= g[1];
      m_we <= (g != 2'b00) && !drop;
      if ((g != 2'b00) && !drop) begin
        m_wreg  <= dst;
        m_wdata <= g[1] ? mem_data : alu_data;
      end
    end
  end

  always @(negedge clk) begin : compare
    bit [1:0] g;
    if (m_init) begin
      g = pred_grant();
      chk("alu_ready", alu_ready, g[0]);
      chk("mem_ready", mem_ready, g[1]);
      chk("iss_ready", iss_ready, pred_iss());
      chk("busy", busy, m_busy);
      chk("write_en", write_en, m_we);
      chk("wreg", wreg, m_wreg);
      chk("writedata", writedata, m_wdata);
      chk("err", err, m_err);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int na;
    int nm;
    logic [3:0] ga;
    logic [3:0] gm;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_busy", busy, 8'h00);
    chk("rst_we", write_en, 1'b0);
    chk("rst_err", err, 1'b0);

    // single ALU write to a marked reg
    iss_valid = 1'b1; iss_reg = 3'd3;
    #1 chk("t1_iss_rdy", iss_ready, 1'b1);
    step();
    iss_valid = 1'b0;
    chk("t1_busy_set", busy, 8'h08);
    alu_valid = 1'b1; alu_wreg = 3'd3; alu_data = 16'h0042;
    #1 chk("t1_alu_rdy", alu_ready, 1'b1);
    chk("t1_mem_rdy", mem_ready, 1'b0);
    step();
    alu_valid = 1'b0;
    chk("t1_we", write_en, 1'b1);
    chk("t1_wreg", wreg, 3'd3);
    chk("t1_wdata", writedata, 16'h0042);
    chk("t1_busy_hold", busy, 8'h08);
    step();
    chk("t1_we_off", write_en, 1'b0);
    chk("t1_busy_clr", busy, 8'h00);
    chk("t1_err", err, 1'b0);

    // both requesters contend for four cycles
    iss_valid = 1'b1; iss_reg = 3'd1;
    step();
    iss_reg = 3'd2;
    step();
    iss_valid = 1'b0;
    chk("t2_busy", busy, 8'h06);
    alu_valid = 1'b1; alu_wreg = 3'd1; alu_data = 16'h1111;
    mem_valid = 1'b1; mem_wreg = 3'd2; mem_data = 16'h2222;
    na = 0; nm = 0; ga = 4'b0; gm = 4'b0;
    for (int k = 0; k < 4; k++) begin
      iss_valid = (k >= 2);
      iss_reg = (k == 2) ? 3'd2 : 3'd1;
      #1;
      ga[k] = alu_ready;
      gm[k] = mem_ready;
      step();
      chk("t2_b2b_we", write_en, 1'b1);
      if (gm[k]) begin
        nm++;
        mem_data = 16'h2223;
        if (nm == 2) mem_valid = 1'b0;
      end
      if (ga[k]) begin
        na++;
        alu_data = 16'h1112;
        if (na == 2) alu_valid = 1'b0;
      end
    end
    iss_valid = 1'b0;
    chk("t2_mem_gnts", gm, 4'b0101);
    chk("t2_alu_gnts", ga, 4'b1010);
    chk("t2_last_data", writedata, 16'h1112);
    step();
    chk("t2_we_off", write_en, 1'b0);
    chk("t2_busy_clr", busy, 8'h00);
    chk("t2_err", err, 1'b0);

    // WAW stall on reg 5
    iss_valid = 1'b1; iss_reg = 3'd5;
    step();
    #1 chk("t3_stall", iss_ready, 1'b0);
    alu_valid = 1'b1; alu_wreg = 3'd5; alu_data = 16'h0555;
    step();
    alu_valid = 1'b0;
    chk("t3_stall_we", iss_ready, 1'b0);
    chk("t3_busy", busy, 8'h20);
    chk("t3_we", write_en, 1'b1);
    step();
    chk("t3_release", iss_ready, 1'b1);
    chk("t3_busy_clr", busy, 8'h00);
    step();
    iss_valid = 1'b0;
    chk("t3_remark", busy, 8'h20);

    // retire to unmarked reg 6, re-marked on the same edge
    alu_valid = 1'b1; alu_wreg = 3'd6; alu_data = 16'h0666;
    step();
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_reg = 3'd6;
    #1 chk("t4_iss_rdy", iss_ready, 1'b1);
    step();
    iss_valid = 1'b0;
    chk("t4_err", err, 1'b1);
    chk("t4_set_wins", busy, 8'h60);
    repeat (2) step();
    chk("t4_err_sticky", err, 1'b1);

    // reset right after a transfer
    alu_valid = 1'b1; alu_wreg = 3'd7; alu_data = 16'h0077;
    step();
    rst = 1'b1;
    mem_valid = 1'b1; mem_wreg = 3'd2;
    iss_valid = 1'b1; iss_reg = 3'd2;
    #1 chk("t5_alu_rdy", alu_ready, 1'b0);
    chk("t5_mem_rdy", mem_ready, 1'b0);
    chk("t5_iss_rdy", iss_ready, 1'b0);
    step();
    chk("t5_we_drop", write_en, 1'b0);
    chk("t5_busy", busy, 8'h00);
    chk("t5_err", err, 1'b0);
    rst = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0; iss_valid = 1'b0;
    step();

    // load result to reg 0
    mem_valid = 1'b1; mem_wreg = 3'd0; mem_data = 16'hFFFF;
    #1 chk("t6_mem_rdy", mem_ready, 1'b1);
    step();
    mem_valid = 1'b0;
`ifdef WB_R0_ZERO_EN
    chk("t6_we", write_en, 1'b0);
    chk("t6_wdata", writedata, 16'h0000);
    chk("t6_busy", busy, 8'h00);
    iss_valid = 1'b1; iss_reg = 3'd0;
    #1 chk("t6_iss_rdy", iss_ready, 1'b1);
    step();
    iss_valid = 1'b0;
    chk("t6_busy0", busy, 8'h00);
    step();
    chk("t6_err", err, 1'b0);
`else
    chk("t6_we", write_en, 1'b1);
    chk("t6_wreg", wreg, 3'd0);
    chk("t6_wdata", writedata, 16'hFFFF);
    step();
    chk("t6_err", err, 1'b1);
`endif
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
